// File: rtl/stage_memory0_arb_pkg.sv
// Shared definitions for the memory0 stage: exception causes, access widths,
// dcache source index width and the alignment helper.
package stage_memory0_arb_pkg;

    typedef enum logic [3:0] {
        EC_INSTR_MISALIGNED = 4'd0,
        EC_INSTR_FAULT      = 4'd1,
        EC_ILLEGAL          = 4'd2,
        EC_BREAKPOINT       = 4'd3,
        EC_LOAD_MISALIGNED  = 4'd4,
        EC_LOAD_FAULT       = 4'd5,
        EC_STORE_MISALIGNED = 4'd6,
        EC_STORE_FAULT      = 4'd7,
        EC_ECALL_U          = 4'd8,
        EC_ECALL_S          = 4'd9,
        EC_ECALL_M          = 4'd11,
        EC_INSTR_PAGE_FAULT = 4'd12,
        EC_LOAD_PAGE_FAULT  = 4'd13,
        EC_STORE_PAGE_FAULT = 4'd15
    } ecause_t;

    localparam logic [1:0] MW_BYTE = 2'd0;
    localparam logic [1:0] MW_HALF = 2'd1;
    localparam logic [1:0] MW_WORD = 2'd2;

    localparam int STARVE_W = 4;

    // dcache source index: 0 = pipeline, i+1 = auxiliary requester i
    function automatic int dc_src_w(input int num_aux);
        return $clog2(num_aux + 1);
    endfunction

    function automatic logic misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if (width == MW_HALF)      mis = addr_lo[0];
        else if (width == MW_WORD) mis = |addr_lo;
        return mis;
    endfunction

endpackage

// File: rtl/stage_memory0_arb_if.sv
// Execute/aux/dcache/memory1 signal bundle seen by the memory0 arbiter;
// slave = the stage itself, master = its surroundings.
interface stage_memory0_arb_if
    import stage_memory0_arb_pkg::*;
#(
    parameter int NUM_AUX = 2
);
    localparam int SRC_W = dc_src_w(NUM_AUX);

    logic                      ex_valid, ex_exc;
    ecause_t                   ex_exc_cause;
    logic [31:2]               ex_pc;
    logic [31:0]               ex_data0, ex_data1;
    logic                      ex_mem_read, ex_mem_write, ex_mem_extend;
    logic [1:0]                ex_mem_width;
    logic [4:0]                ex_wb_reg;
    logic                      mem0_stall;

    logic [NUM_AUX-1:0]        aux_req, aux_trans, aux_gnt;
    logic [NUM_AUX-1:0][31:2]  aux_addr;

    logic                      mem0_dc_read, mem0_dc_trans;
    logic [8:0]                mem0_dc_asid;
    logic [31:2]               mem0_dc_addr;
    logic [SRC_W-1:0]          mem0_dc_src;

    logic                      csr_kill;
    logic [31:0]               csr_satp;

    logic                      mem1_stall;
    logic                      mem0_valid, mem0_exc;
    ecause_t                   mem0_exc_cause;
    logic [31:2]               mem0_pc;
    logic                      mem0_read, mem0_write, mem0_extend;
    logic [1:0]                mem0_width;
    logic [31:0]               mem0_addr, mem0_wdata;
    logic [4:0]                mem0_wb_reg;

    logic                      mem0_fwd_valid, mem0_fwd_stall;
    logic [31:0]               mem0_fwd_data;

    modport slave (
        input  ex_valid, ex_exc, ex_exc_cause, ex_pc, ex_data0, ex_data1,
               ex_mem_read, ex_mem_write, ex_mem_extend, ex_mem_width, ex_wb_reg,
               aux_req, aux_trans, aux_addr, csr_kill, csr_satp, mem1_stall,
        output mem0_stall, aux_gnt,
               mem0_dc_read, mem0_dc_trans, mem0_dc_asid, mem0_dc_addr, mem0_dc_src,
               mem0_valid, mem0_exc, mem0_exc_cause, mem0_pc, mem0_read, mem0_write,
               mem0_extend, mem0_width, mem0_addr, mem0_wdata, mem0_wb_reg,
               mem0_fwd_valid, mem0_fwd_stall, mem0_fwd_data
    );

    modport master (
        output ex_valid, ex_exc, ex_exc_cause, ex_pc, ex_data0, ex_data1,
               ex_mem_read, ex_mem_write, ex_mem_extend, ex_mem_width, ex_wb_reg,
               aux_req, aux_trans, aux_addr, csr_kill, csr_satp, mem1_stall,
        input  mem0_stall, aux_gnt,
               mem0_dc_read, mem0_dc_trans, mem0_dc_asid, mem0_dc_addr, mem0_dc_src,
               mem0_valid, mem0_exc, mem0_exc_cause, mem0_pc, mem0_read, mem0_write,
               mem0_extend, mem0_width, mem0_addr, mem0_wdata, mem0_wb_reg,
               mem0_fwd_valid, mem0_fwd_stall, mem0_fwd_data
    );

endinterface

// File: rtl/stage_memory0_arb_rr_prio.sv
// dcache port priority encoder: lowest-index aux wins, except the pipeline
// op is forced through after STARVE_MAX consecutive losses.
module mem0_rr_prio
    import stage_memory0_arb_pkg::*;
#(
    parameter int NUM_AUX    = 2,
    parameter int STARVE_MAX = 3,
    parameter int SRC_W      = dc_src_w(NUM_AUX)
) (
    input  logic               clk_core,
    input  logic               reset_n,
    input  logic               pipe_cand_i,
    input  logic [NUM_AUX-1:0] aux_req_i,
    output logic               pipe_gnt_o,
    output logic [NUM_AUX-1:0] aux_gnt_o,
    output logic [SRC_W-1:0]   src_o
);

    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                aux_hit;

    always_comb begin
        pipe_gnt_o = 1'b0;
        aux_gnt_o  = '0;
        src_o      = '0;
        aux_hit    = 1'b0;
        if (pipe_cand_i && (starve_q == STARVE_W'(STARVE_MAX))) begin
            pipe_gnt_o = 1'b1;
        end else begin
            for (int i = 0; i < NUM_AUX; i++) begin
                if (aux_req_i[i] && !aux_hit) begin
                    aux_hit      = 1'b1;
                    aux_gnt_o[i] = 1'b1;
                    src_o        = SRC_W'(i + 1);
                end
            end
            pipe_gnt_o = pipe_cand_i && !aux_hit;
        end
    end

    // Counts only uninterrupted losses; any grant or idle cycle restarts it
    always_comb begin
        starve_d = '0;
        if (pipe_cand_i && !pipe_gnt_o)
            starve_d = (starve_q == STARVE_W'(STARVE_MAX)) ? starve_q : starve_q + STARVE_W'(1);
    end

    always_ff @(posedge clk_core) begin
        if (!reset_n) starve_q <= '0;
        else          starve_q <= starve_d;
    end

endmodule

// File: rtl/stage_memory0_arb.sv
// Memory0 stage: holds the execute bundle and arbitrates the dcache port
// between it and auxiliary requesters. MEM0_MISALIGN_EXC_EN adds alignment traps.
module stage_memory0_arb
    import stage_memory0_arb_pkg::*;
#(
    parameter int NUM_AUX    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic                 clk_core,
    input  logic                 reset_n,
    stage_memory0_arb_if.slave   bus
);

    localparam int SRC_W = dc_src_w(NUM_AUX);

    logic        valid_q, exc_q, exc_d;
    ecause_t     cause_q, cause_d;
    logic [31:2] pc_q;
    logic [31:0] data0_q, data1_q;
    logic        read_q, write_q, extend_q;
    logic [1:0]  width_q;
    logic [4:0]  wb_reg_q;

    logic               pipe_cand, alu_op, pipe_gnt, any_aux, stall, capture;
    logic [NUM_AUX-1:0] aux_gnt;
    logic [SRC_W-1:0]   src;
    logic               aux_trans_sel;
    logic [31:2]        aux_addr_sel;
    logic               unused_satp;

`ifdef MEM0_MISALIGN_EXC_EN
    logic mis;
    assign mis     = bus.ex_valid && !bus.ex_exc && (bus.ex_mem_read || bus.ex_mem_write)
                     && misaligned(bus.ex_mem_width, bus.ex_data0[1:0]);
    assign exc_d   = bus.ex_exc || mis;
    assign cause_d = mis ? (bus.ex_mem_read ? EC_LOAD_MISALIGNED : EC_STORE_MISALIGNED)
                         : bus.ex_exc_cause;
`else
    assign exc_d   = bus.ex_exc;
    assign cause_d = bus.ex_exc_cause;
`endif

    // A kill always admits the next bundle, even while memory1 is stalled
    assign capture = !stall || bus.csr_kill;

    always_ff @(posedge clk_core) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            exc_q   <= 1'b0;
        end else if (capture) begin
            valid_q <= bus.ex_valid;
            exc_q   <= exc_d;
        end
    end

    always_ff @(posedge clk_core) begin
        if (capture) begin
            cause_q  <= cause_d;
            pc_q     <= bus.ex_pc;
            data0_q  <= bus.ex_data0;
            data1_q  <= bus.ex_data1;
            read_q   <= bus.ex_mem_read;
            write_q  <= bus.ex_mem_write;
            extend_q <= bus.ex_mem_extend;
            width_q  <= bus.ex_mem_width;
            wb_reg_q <= bus.ex_wb_reg;
        end
    end

    assign pipe_cand = valid_q && !exc_q && (read_q || write_q);
    assign alu_op    = valid_q && !exc_q && !read_q && !write_q;

    mem0_rr_prio #(
        .NUM_AUX    (NUM_AUX),
        .STARVE_MAX (STARVE_MAX),
        .SRC_W      (SRC_W)
    ) u_prio (
        .clk_core    (clk_core),
        .reset_n     (reset_n),
        .pipe_cand_i (pipe_cand),
        .aux_req_i   (bus.aux_req),
        .pipe_gnt_o  (pipe_gnt),
        .aux_gnt_o   (aux_gnt),
        .src_o       (src)
    );

    assign any_aux = |aux_gnt;

    always_comb begin
        aux_trans_sel = 1'b0;
        aux_addr_sel  = '0;
        for (int i = 0; i < NUM_AUX; i++) begin
            if (aux_gnt[i]) begin
                aux_trans_sel = bus.aux_trans[i];
                aux_addr_sel  = bus.aux_addr[i];
            end
        end
    end

    // An aux grant occupies the memory1 slot, so a non-memory op must wait too
    assign stall = (valid_q || exc_q) &&
                   (bus.mem1_stall || (pipe_cand && !pipe_gnt) || (alu_op && any_aux));

    assign bus.mem0_stall     = stall;
    assign bus.aux_gnt        = aux_gnt;
    assign bus.mem0_dc_read   = any_aux || (pipe_gnt && !bus.mem1_stall);
    assign bus.mem0_dc_trans  = any_aux ? aux_trans_sel : bus.csr_satp[31];
    assign bus.mem0_dc_asid   = bus.csr_satp[30:22];
    assign bus.mem0_dc_addr   = any_aux ? aux_addr_sel : data0_q[31:2];
    assign bus.mem0_dc_src    = src;
    assign unused_satp        = ^bus.csr_satp[21:0];

    assign bus.mem0_valid     = ((valid_q && !exc_q && !stall) || any_aux) && !bus.csr_kill;
    assign bus.mem0_exc       = exc_q && !any_aux && !bus.csr_kill;
    assign bus.mem0_exc_cause = cause_q;
    assign bus.mem0_pc        = pc_q;
    assign bus.mem0_read      = read_q;
    assign bus.mem0_write     = write_q;
    assign bus.mem0_extend    = extend_q;
    assign bus.mem0_width     = width_q;
    assign bus.mem0_addr      = any_aux ? {aux_addr_sel, 2'b00} : data0_q;
    assign bus.mem0_wdata     = data1_q;
    assign bus.mem0_wb_reg    = wb_reg_q;

    assign bus.mem0_fwd_valid = valid_q;
    assign bus.mem0_fwd_stall = read_q;
    assign bus.mem0_fwd_data  = data0_q;

endmodule

// File: tb/tb_stage_memory0_arb.sv
// Directed bench for stage_memory0_arb: per-cycle vector table plus short
// hand sequences for alignment, forwarding and mid-transaction reset.
module tb_stage_memory0_arb;
    import stage_memory0_arb_pkg::*;

    localparam int NA = 2;

    localparam logic [3:0] IDL = 4'b0000;  // {valid, exc, read, write}
    localparam logic [3:0] LD  = 4'b1010;
    localparam logic [3:0] ST  = 4'b1001;
    localparam logic [3:0] ALU = 4'b1000;
    localparam logic [3:0] EXC = 4'b1100;
    localparam logic [1:0] W   = 2'd2;

    logic clk_core = 1'b0;
    logic reset_n  = 1'b0;
    always #5 clk_core = ~clk_core;

    stage_memory0_arb_if #(.NUM_AUX(NA)) bus();

    stage_memory0_arb #(.NUM_AUX(NA), .STARVE_MAX(3)) dut (
        .clk_core (clk_core),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    typedef struct {
        string       nm;
        logic [3:0]  ex;
        logic [1:0]  wid;
        logic [31:0] ea;
        logic [1:0]  areq;
        logic        m1s, kill;
        logic [1:0]  gnt;
        logic        rd;
        logic [1:0]  src;
        logic        ca;
        logic [29:0] addr;
        logic        trn, stall, vld, exc;
    } vec_t;

    vec_t vt[$];
    int   n_run  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(string nm, logic [3:0] ex, logic [1:0] wid, logic [31:0] ea,
                                logic [1:0] areq, logic m1s, logic kill, logic [1:0] gnt,
                                logic rd, logic [1:0] src, logic ca, logic [29:0] addr,
                                logic trn, logic stall, logic vld, logic exc);
        vec_t r;
        r.nm = nm; r.ex = ex; r.wid = wid; r.ea = ea; r.areq = areq; r.m1s = m1s;
        r.kill = kill; r.gnt = gnt; r.rd = rd; r.src = src; r.ca = ca; r.addr = addr;
        r.trn = trn; r.stall = stall; r.vld = vld; r.exc = exc;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply_in(input logic [3:0] ex, input logic [1:0] wid, input logic [31:0] ea,
                            input logic [1:0] areq, input logic m1s, input logic kill);
        bus.ex_valid     = ex[3];
        bus.ex_exc       = ex[2];
        bus.ex_mem_read  = ex[1];
        bus.ex_mem_write = ex[0];
        bus.ex_mem_width = wid;
        bus.ex_data0     = ea;
        bus.aux_req      = areq;
        bus.mem1_stall   = m1s;
        bus.csr_kill     = kill;
    endtask

    initial begin
        bus.ex_exc_cause  = EC_ILLEGAL;
        bus.ex_pc         = 30'h0000_0040;
        bus.ex_data1      = 32'h1234_5678;
        bus.ex_mem_extend = 1'b0;
        bus.ex_wb_reg     = 5'd7;
        bus.aux_trans     = 2'b10;
        bus.aux_addr[0]   = 30'h100;
        bus.aux_addr[1]   = 30'h200;
        bus.csr_satp      = {1'b1, 9'h155, 22'h0};
        apply_in(IDL, W, 32'h0, 2'b00, 1'b0, 1'b0);

        //        name            ex   wid ea            areq  m1s kill gnt   rd src   ca addr      trn st vld exc
        vt.push_back(mk("ld0_cap",     LD,  W, 32'h1000, 2'b00, 0, 0, 2'b00, 0, 2'd0, 0, 30'h0,   0, 0, 0, 0));
        vt.push_back(mk("ld0_issue",   IDL, W, 32'h0,    2'b00, 0, 0, 2'b00, 1, 2'd0, 1, 30'h400, 1, 0, 1, 0));
        vt.push_back(mk("st_cap",      ST,  W, 32'h2000, 2'b00, 0, 0, 2'b00, 0, 2'd0, 0, 30'h0,   0, 0, 0, 0));
        vt.push_back(mk("starve1",     IDL, W, 32'h0,    2'b01, 0, 0, 2'b01, 1, 2'd1, 1, 30'h100, 0, 1, 1, 0));
        vt.push_back(mk("starve2",     IDL, W, 32'h0,    2'b01, 0, 0, 2'b01, 1, 2'd1, 1, 30'h100, 0, 1, 1, 0));
        vt.push_back(mk("starve3",     IDL, W, 32'h0,    2'b01, 0, 0, 2'b01, 1, 2'd1, 1, 30'h100, 0, 1, 1, 0));
        vt.push_back(mk("starve_force",IDL, W, 32'h0,    2'b01, 0, 0, 2'b00, 1, 2'd0, 1, 30'h800, 1, 0, 1, 0));
        vt.push_back(mk("aux_after",   IDL, W, 32'h0,    2'b01, 0, 0, 2'b01, 1, 2'd1, 1, 30'h100, 0, 0, 1, 0));
        vt.push_back(mk("st2_cap",     ST,  W, 32'h3000, 2'b00, 0, 0, 2'b00, 0, 2'd0, 0, 30'h0,   0, 0, 0, 0));
        vt.push_back(mk("cnt_clr_aux", IDL, W, 32'h0,    2'b01, 0, 0, 2'b01, 1, 2'd1, 1, 30'h100, 0, 1, 1, 0));
        vt.push_back(mk("cnt_clr_pipe",IDL, W, 32'h0,    2'b00, 0, 0, 2'b00, 1, 2'd0, 1, 30'hC00, 1, 0, 1, 0));
        vt.push_back(mk("both_req",    IDL, W, 32'h0,    2'b11, 0, 0, 2'b01, 1, 2'd1, 1, 30'h100, 0, 0, 1, 0));
        vt.push_back(mk("aux1_req",    IDL, W, 32'h0,    2'b10, 0, 0, 2'b10, 1, 2'd2, 1, 30'h200, 1, 0, 1, 0));
        vt.push_back(mk("ld_cap2",     LD,  W, 32'h1000, 2'b00, 0, 0, 2'b00, 0, 2'd0, 0, 30'h0,   0, 0, 0, 0));
        vt.push_back(mk("m1s_pipe",    IDL, W, 32'h0,    2'b00, 1, 0, 2'b00, 0, 2'd0, 1, 30'h400, 0, 1, 0, 0));
        vt.push_back(mk("m1s_aux",     IDL, W, 32'h0,    2'b01, 1, 0, 2'b01, 1, 2'd1, 1, 30'h100, 0, 1, 1, 0));
        vt.push_back(mk("kill",        LD,  W, 32'h2000, 2'b00, 1, 1, 2'b00, 0, 2'd0, 1, 30'h400, 0, 1, 0, 0));
        vt.push_back(mk("post_kill",   IDL, W, 32'h0,    2'b00, 0, 0, 2'b00, 1, 2'd0, 1, 30'h800, 1, 0, 1, 0));
        vt.push_back(mk("alu_cap",     ALU, W, 32'h5000, 2'b00, 0, 0, 2'b00, 0, 2'd0, 0, 30'h0,   0, 0, 0, 0));
        vt.push_back(mk("alu_aux",     IDL, W, 32'h0,    2'b10, 0, 0, 2'b10, 1, 2'd2, 1, 30'h200, 1, 1, 1, 0));
        vt.push_back(mk("alu_go",      IDL, W, 32'h0,    2'b00, 0, 0, 2'b00, 0, 2'd0, 1, 30'h1400,0, 0, 1, 0));
        vt.push_back(mk("exc_cap",     EXC, W, 32'h0,    2'b00, 0, 0, 2'b00, 0, 2'd0, 0, 30'h0,   0, 0, 0, 0));
        vt.push_back(mk("exc_out",     IDL, W, 32'h0,    2'b00, 0, 0, 2'b00, 0, 2'd0, 0, 30'h0,   0, 0, 0, 1));
        vt.push_back(mk("exc_cap2",    EXC, W, 32'h0,    2'b00, 0, 0, 2'b00, 0, 2'd0, 0, 30'h0,   0, 0, 0, 0));
        vt.push_back(mk("exc_kill",    IDL, W, 32'h0,    2'b00, 0, 1, 2'b00, 0, 2'd0, 0, 30'h0,   0, 0, 0, 0));
        vt.push_back(mk("mis_cap",     LD,  W, 32'h1002, 2'b00, 0, 0, 2'b00, 0, 2'd0, 0, 30'h0,   0, 0, 0, 0));
`ifdef MEM0_MISALIGN_EXC_EN
        vt.push_back(mk("mis_out",     IDL, W, 32'h0,    2'b00, 0, 0, 2'b00, 0, 2'd0, 0, 30'h0,   0, 0, 0, 1));
`else
        vt.push_back(mk("mis_out",     IDL, W, 32'h0,    2'b00, 0, 0, 2'b00, 1, 2'd0, 1, 30'h400, 1, 0, 1, 0));
`endif
        vt.push_back(mk("idle_end",    IDL, W, 32'h0,    2'b00, 0, 0, 2'b00, 0, 2'd0, 0, 30'h0,   0, 0, 0, 0));

        // Reset state
        repeat (2) @(negedge clk_core);
        #1;
        chk("rst_gnt",   32'(bus.aux_gnt),      32'h0);
        chk("rst_rd",    32'(bus.mem0_dc_read), 32'h0);
        chk("rst_vld",   32'(bus.mem0_valid),   32'h0);
        chk("rst_exc",   32'(bus.mem0_exc),     32'h0);
        chk("rst_stall", 32'(bus.mem0_stall),   32'h0);
        chk("rst_asid",  32'(bus.mem0_dc_asid), 32'h155);
        reset_n = 1'b1;

        foreach (vt[k]) begin
            @(negedge clk_core);
            apply_in(vt[k].ex, vt[k].wid, vt[k].ea, vt[k].areq, vt[k].m1s, vt[k].kill);
            #1;
            chk({vt[k].nm, ".gnt"},   32'(bus.aux_gnt),      32'(vt[k].gnt));
            chk({vt[k].nm, ".rd"},    32'(bus.mem0_dc_read), 32'(vt[k].rd));
            chk({vt[k].nm, ".src"},   32'(bus.mem0_dc_src),  32'(vt[k].src));
            chk({vt[k].nm, ".stall"}, 32'(bus.mem0_stall),   32'(vt[k].stall));
            chk({vt[k].nm, ".vld"},   32'(bus.mem0_valid),   32'(vt[k].vld));
            chk({vt[k].nm, ".exc"},   32'(bus.mem0_exc),     32'(vt[k].exc));
            if (vt[k].ca) chk({vt[k].nm, ".addr"},  32'(bus.mem0_dc_addr),  32'(vt[k].addr));
            if (vt[k].rd) chk({vt[k].nm, ".trans"}, 32'(bus.mem0_dc_trans), 32'(vt[k].trn));
        end

        // Byte access is never misaligned; half store at odd address is
        @(negedge clk_core);
        apply_in(LD, MW_BYTE, 32'h1003, 2'b00, 1'b0, 1'b0);
        @(negedge clk_core);
        apply_in(ST, MW_HALF, 32'h1001, 2'b00, 1'b0, 1'b0);
        bus.ex_data1 = 32'hDEAD_BEEF;
        #1;
        chk("byte_rd",       32'(bus.mem0_dc_read),   32'h1);
        chk("byte_addr",     32'(bus.mem0_dc_addr),   32'h400);
        chk("byte_maddr",    bus.mem0_addr,           32'h1003);
        chk("byte_fwdstall", 32'(bus.mem0_fwd_stall), 32'h1);
        @(negedge clk_core);
        apply_in(LD, W, 32'h1002, 2'b00, 1'b0, 1'b0);
        #1;
        chk("half_fwdvld",   32'(bus.mem0_fwd_valid), 32'h1);
        chk("half_fwddata",  bus.mem0_fwd_data,       32'h1001);
`ifdef MEM0_MISALIGN_EXC_EN
        chk("half_exc",      32'(bus.mem0_exc),       32'h1);
        chk("half_cause",    32'(bus.mem0_exc_cause), 32'(EC_STORE_MISALIGNED));
        chk("half_rd",       32'(bus.mem0_dc_read),   32'h0);
`else
        chk("half_rd",       32'(bus.mem0_dc_read),   32'h1);
        chk("half_addr",     32'(bus.mem0_dc_addr),   32'h400);
        chk("half_wdata",    bus.mem0_wdata,          32'hDEAD_BEEF);
`endif
        @(negedge clk_core);
        apply_in(IDL, W, 32'h0, 2'b00, 1'b0, 1'b0);
        #1;
`ifdef MEM0_MISALIGN_EXC_EN
        chk("wld_cause",     32'(bus.mem0_exc_cause), 32'(EC_LOAD_MISALIGNED));
        chk("wld_rd",        32'(bus.mem0_dc_read),   32'h0);
`else
        chk("wld_rd",        32'(bus.mem0_dc_read),   32'h1);
        chk("wld_addr",      32'(bus.mem0_dc_addr),   32'h400);
`endif

        // Reset while a load is stalled behind memory1
        @(negedge clk_core);
        apply_in(LD, W, 32'h1000, 2'b00, 1'b0, 1'b0);
        @(negedge clk_core);
        apply_in(IDL, W, 32'h0, 2'b00, 1'b1, 1'b0);
        #1;
        chk("rstmid_stall_pre", 32'(bus.mem0_stall), 32'h1);
        reset_n = 1'b0;
        @(negedge clk_core);
        #1;
        chk("rstmid_stall", 32'(bus.mem0_stall),   32'h0);
        chk("rstmid_rd",    32'(bus.mem0_dc_read), 32'h0);
        chk("rstmid_vld",   32'(bus.mem0_valid),   32'h0);
        reset_n = 1'b1;
        bus.mem1_stall = 1'b0;
        @(negedge clk_core);
        #1;
        chk("rstmid_dropped", 32'(bus.mem0_dc_read), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/stage_memory0_arb.md
STAGE_MEMORY0_ARB -- requirements
Module: stage_memory0_arb

Interface
REQ-001 SHALL have parameter NUM_AUX, default 2, number of auxiliary dcache requesters (fetch1 refill, mem1 page walk, ...), range 1..4.
REQ-002 SHALL have parameter STARVE_MAX, default 3, consecutive pipeline losses before the pipeline op is forced through, range 1..15.
REQ-003 SHALL have port clk_core  input  1  core clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports ex_valid/ex_exc  input  1 each  execute stage bundle valid / carries exception.
REQ-006 SHALL have ports ex_exc_cause (ecause_t), ex_pc [31:2], ex_data0 32 (address), ex_data1 32 (store data), ex_mem_read 1, ex_mem_write 1, ex_mem_extend 1, ex_mem_width 2, ex_wb_reg 5  input  execute bundle.
REQ-007 SHALL have port mem0_stall  output  1  backpressure to execute.
REQ-008 SHALL have ports aux_req [NUM_AUX], aux_trans [NUM_AUX], aux_addr [NUM_AUX][31:2]  input  auxiliary requests; aux_gnt [NUM_AUX]  output  one-hot grant.
REQ-009 SHALL have ports mem0_dc_read 1, mem0_dc_trans 1, mem0_dc_asid 9, mem0_dc_addr [31:2], mem0_dc_src $clog2(NUM_AUX+1)  output  dcache request; src 0 = pipeline, i+1 = aux i.
REQ-010 SHALL have ports csr_kill 1, csr_satp 32  input  pipeline flush / translation control.
REQ-011 SHALL have ports mem1_stall  input  1; mem0_valid, mem0_exc 1, mem0_exc_cause, mem0_pc, mem0_read, mem0_write, mem0_extend, mem0_width, mem0_addr 32, mem0_wdata 32, mem0_wb_reg  output  memory1 bundle.
REQ-012 SHALL have ports mem0_fwd_valid, mem0_fwd_stall 1, mem0_fwd_data 32  output  decode forwarding.

Function
REQ-013 Bundle register SHALL load from execute when ~mem0_stall | csr_kill; otherwise hold.
REQ-014 Pipeline candidate = valid & ~exc & (mem0_read | mem0_write); aux candidate i = aux_req[i].
REQ-015 Arbitration: if starve counter == STARVE_MAX and pipeline candidate, pipeline wins; else lowest-index aux wins; else pipeline; exactly one grant per cycle, zero when no candidates.
REQ-016 Starve counter SHALL increment (saturating at STARVE_MAX) when pipeline candidate loses and clear when pipeline granted or not a candidate.
REQ-017 mem0_dc_read SHALL equal "any grant", except pipeline grant also requires ~mem1_stall; dc_trans = satp[31] for pipeline, aux_trans[i] for aux; dc_asid = satp[30:22] always.
REQ-018 mem0_stall = (valid | exc) & (mem1_stall | (pipeline candidate & ~pipeline granted) | (exc-free valid non-memory op & any aux grant)).
REQ-019 mem0_valid = ((valid & ~exc & ~mem0_stall) | aux grant) & ~csr_kill; mem0_exc = exc & ~aux grant & ~csr_kill.
REQ-020 mem0_addr SHALL be registered ex_data0 for pipeline grant/no grant, {dc_addr,2'b0} for aux grant.
REQ-021 Forwarding: fwd_valid = valid, fwd_stall = mem0_read, fwd_data = registered ex_data0.
REQ-022 csr_kill SHALL suppress mem0_valid/mem0_exc same cycle and not affect aux grants or the starve counter.
REQ-023 Simultaneous aux_req and mem1_stall: aux grant SHALL still issue; aux requesters hold aux_req until aux_gnt.

Reset
REQ-024 On reset: valid=0, exc=0, starve counter=0; hence aux_gnt=0, mem0_dc_read=0, mem0_valid=0, mem0_exc=0, mem0_stall=0 (absent aux_req); data registers undefined.
REQ-025 Reset mid-transaction SHALL drop pending pipeline op; aux requesters re-request.

Configuration
REQ-026 Macro MEM0_MISALIGN_EXC_EN: defined -> half with addr[0]!=0 or word with addr[1:0]!=0 sets exc at capture, cause LOAD/STORE_ADDR_MISALIGNED, no dcache read; undefined -> no check, op passes unmodified.

Structure
REQ-027 ecause_t and misaligned cause encodings SHALL live in the shared defines package; dcache source index width constant there too.
REQ-028 Sub-module mem0_rr_prio (priority encoder + starve counter) is natural; rest stays in the top.

Verification
REQ-029 Reset, then ex load addr 0x1000 valid, no aux -> next cycle dc_read=1, dc_addr=0x400, dc_src=0, mem0_valid=1.
REQ-030 aux_req[0] held with pipeline store pending, STARVE_MAX=3 -> aux 0 wins 3 cycles (mem0_stall=1), 4th cycle pipeline granted, counter cleared.
REQ-031 aux_req=2'b11 simultaneously -> aux_gnt=2'b01, then 2'b10 after aux 0 drops.
REQ-032 Valid load, mem1_stall=1 then csr_kill pulse -> mem0_valid=0 during kill, new bundle captured, no dc_read for killed op.
REQ-033 With MEM0_MISALIGN_EXC_EN, word load at 0x1002 -> mem0_exc=1, cause LOAD_ADDR_MISALIGNED, dc_read=0; without macro -> dc_read=1, dc_addr=0x400.
